// File: rtl/mem_le_ram.sv
// rtl/mem_le_ram.sv - parametrised single-clock RAM with lane writes, read valid and hardware clear
module mem_le_ram #(
  parameter int DATA_W  = 4,
  parameter int ADDR_W  = 5,
  parameter int LANE_W  = 4,
  parameter int RDW_NEW = 0
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [ADDR_W-1:0]        address,
  input  logic [DATA_W-1:0]        data,
  input  logic                     wren,
  input  logic [DATA_W/LANE_W-1:0] ben,
  input  logic                     rden,
  input  logic                     clear,
  output logic [DATA_W-1:0]        q,
  output logic                     q_valid,
  output logic                     busy
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int LANES = DATA_W / LANE_W;

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_old;
  logic [DATA_W-1:0] rd_merged;
  logic              access;

  assign access = (state == S_IDLE) && !clear;
  assign rd_old = mem[address];

  // Word as it will look after this edge's write; also the new-data read path.
  always_comb begin
    rd_merged = rd_old;
    for (int i = 0; i < LANES; i++) begin
      if (ben[i]) rd_merged[i*LANE_W +: LANE_W] = data[i*LANE_W +: LANE_W];
    end
  end

  // Reset forces S_CLEAR, so a write on an edge with reset_n low is dropped.
  always_ff @(posedge clock) begin
    if (state == S_CLEAR) mem[cnt] <= '0;
    else if (access && wren) mem[address] <= rd_merged;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_CLEAR;
      cnt     <= '0;
      busy    <= 1'b1;
      q       <= '0;
      q_valid <= 1'b0;
    end else begin
      case (state)
        S_CLEAR: begin
          q_valid <= 1'b0;
          if (cnt == ADDR_W'(DEPTH-1)) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (clear) begin
            state   <= S_CLEAR;
            busy    <= 1'b1;
            cnt     <= '0;
            q_valid <= 1'b0;
          end else if (rden) begin
            q       <= (RDW_NEW != 0 && wren) ? rd_merged : rd_old;
            q_valid <= 1'b1;
          end else begin
            q_valid <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_le_ram.sv
// tb/tb_mem_le_ram.sv - checks old- and new-data RAM variants against a behavioural model
module tb_mem_le_ram;
  logic       clock = 0;
  logic       reset_n = 0;
  logic [4:0] address = 0;
  logic [7:0] data = 0;
  logic       wren = 0;
  logic [1:0] ben = 0;
  logic       rden = 0;
  logic       clear = 0;
  logic [7:0] q0, q1;
  logic       v0, v1, b0, b1;

  int total = 0;
  int bad = 0;
  bit chk_en = 0;

  mem_le_ram #(.DATA_W(8), .ADDR_W(5), .LANE_W(4), .RDW_NEW(0)) u_old (
    .clock(clock), .reset_n(reset_n), .address(address), .data(data), .wren(wren),
    .ben(ben), .rden(rden), .clear(clear), .q(q0), .q_valid(v0), .busy(b0));

  mem_le_ram #(.DATA_W(8), .ADDR_W(5), .LANE_W(4), .RDW_NEW(1)) u_new (
    .clock(clock), .reset_n(reset_n), .address(address), .data(data), .wren(wren),
    .ben(ben), .rden(rden), .clear(clear), .q(q1), .q_valid(v1), .busy(b1));

  always #5 clock = ~clock;

  // Model: the array is conceptually zero from the start of any clear; busy_left counts edges.
  logic [7:0] mmem [32];
  int         busy_left;
  logic [7:0] mq0, mq1, old_w, new_w;
  logic       mv;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) mmem[i] = 8'h00;
      busy_left = 32; mq0 = 0; mq1 = 0; mv = 0;
    end else if (busy_left > 0) begin
      busy_left = busy_left - 1; mv = 0;
    end else if (clear) begin
      for (int i = 0; i < 32; i++) mmem[i] = 8'h00;
      busy_left = 32; mv = 0;
    end else begin
      old_w = mmem[address];
      new_w = {ben[1] ? data[7:4] : old_w[7:4], ben[0] ? data[3:0] : old_w[3:0]};
      if (wren) mmem[address] = new_w;
      if (rden) begin
        mq0 = old_w;
        mq1 = wren ? new_w : old_w;
        mv = 1;
      end else mv = 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("model_busy_old", {31'd0, b0}, {31'd0, busy_left > 0});
      chk("model_busy_new", {31'd0, b1}, {31'd0, busy_left > 0});
      chk("model_valid_old", {31'd0, v0}, {31'd0, mv});
      chk("model_valid_new", {31'd0, v1}, {31'd0, mv});
      chk("model_q_old", {24'd0, q0}, {24'd0, mq0});
      chk("model_q_new", {24'd0, q1}, {24'd0, mq1});
    end
  end

  task automatic idle(input int n);
    wren = 0; rden = 0; clear = 0;
    repeat (n) @(negedge clock);
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d, input logic [1:0] b);
    address = a; data = d; ben = b; wren = 1; rden = 0; clear = 0;
    @(negedge clock);
    wren = 0;
  endtask

  task automatic rd(input string nm, input logic [4:0] a, input logic [7:0] e0, input logic [7:0] e1);
    address = a; rden = 1; wren = 0; clear = 0;
    @(negedge clock);
    rden = 0;
    chk({nm, "_q_old"}, {24'd0, q0}, {24'd0, e0});
    chk({nm, "_q_new"}, {24'd0, q1}, {24'd0, e1});
    chk({nm, "_valid"}, {30'd0, v0, v1}, 32'd3);
  endtask

  task automatic count_busy(input string nm, input logic hold_rden);
    int n = 0;
    rden = hold_rden;
    while ((b0 || b1) && n < 100) begin
      @(negedge clock);
      n++;
    end
    rden = 0;
    chk(nm, n, 32);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk_en = 1;
    @(negedge clock);
    chk("reset_state", {22'd0, b0, b1, v0, v1, q0 | q1}, {22'd0, 4'b1100, 8'h00});
    reset_n = 1;
    count_busy("busy_after_reset", 1'b0);

    rd("t1_a00", 5'h00, 8'h00, 8'h00);
    rd("t1_a1f", 5'h1F, 8'h00, 8'h00);
    rd("t1_a0a", 5'h0A, 8'h00, 8'h00);

    wr(5'h01, 8'h0A, 2'b11);
    wr(5'h02, 8'h0B, 2'b11);
    wr(5'h03, 8'h0C, 2'b11);
    rd("t2_a01", 5'h01, 8'h0A, 8'h0A);
    rd("t2_a02", 5'h02, 8'h0B, 8'h0B);
    rd("t2_a03", 5'h03, 8'h0C, 8'h0C);
    idle(2);
    chk("t2_hold", {22'd0, v0, v1, q0}, {24'd0, 8'h0C});

    wr(5'h04, 8'h5A, 2'b11);
    wr(5'h04, 8'hF3, 2'b10);
    rd("t3_lane", 5'h04, 8'hFA, 8'hFA);
    wr(5'h04, 8'h77, 2'b00);
    rd("t3_ben0", 5'h04, 8'hFA, 8'hFA);

    wr(5'h05, 8'h02, 2'b11);
    address = 5'h05; data = 8'h07; ben = 2'b11; wren = 1; rden = 1;
    @(negedge clock);
    wren = 0; rden = 0;
    chk("t4_rdw_old", {24'd0, q0}, 32'h02);
    chk("t4_rdw_new", {24'd0, q1}, 32'h07);
    rd("t4_after", 5'h05, 8'h07, 8'h07);

    wr(5'h06, 8'h34, 2'b11);
    address = 5'h06; data = 8'hAB; ben = 2'b01; wren = 1; rden = 1;
    @(negedge clock);
    wren = 0; rden = 0;
    chk("rdw_merge_old", {24'd0, q0}, 32'h34);
    chk("rdw_merge_new", {24'd0, q1}, 32'h3B);
    rd("merge_after", 5'h06, 8'h3B, 8'h3B);

    wr(5'h10, 8'h09, 2'b11);
    address = 5'h11; data = 8'h55; ben = 2'b11; wren = 1; clear = 1;
    @(negedge clock);
    wren = 0; clear = 0;
    count_busy("busy_after_clear", 1'b1);
    chk("t5_q_held", {24'd0, q0}, 32'h3B);
    rd("t5_a10", 5'h10, 8'h00, 8'h00);
    rd("t5_a11", 5'h11, 8'h00, 8'h00);

    wr(5'h07, 8'hC3, 2'b11);
    wr(5'h1F, 8'h81, 2'b11);
    clear = 1;
    @(negedge clock);
    clear = 0;
    repeat (12) @(negedge clock);
    reset_n = 0;
    @(negedge clock);
    chk("t6_in_reset", {22'd0, b0, b1, v0, v1, q0 | q1}, {22'd0, 4'b1100, 8'h00});
    reset_n = 1;
    count_busy("busy_after_midclear_reset", 1'b0);
    for (int a = 0; a < 32; a++) rd("t6_zero", 5'(a), 8'h00, 8'h00);

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_le_ram.md
Name: mem_le_ram

Overview:
Parametrised single-clock synchronous RAM; next generation of the small 32x4 switch/key memory used on the board labs. Adds configurable width and depth, per-lane write enables, an explicit read enable with a valid flag, and a selectable read-during-write mode. A hardware clear FSM zeroes the whole array after reset or on request, with a busy indication. It serves as the default on-chip storage block for datapath and lab designs.

Parameters:
DATA_W, 4, word width in bits; must be a multiple of LANE_W
ADDR_W, 5, address width; DEPTH = 2**ADDR_W words
LANE_W, 4, bits per write lane; LANES = DATA_W/LANE_W
RDW_NEW, 0, read-during-write to the same address: 0 returns old data, 1 returns newly written (lane-merged) data

Ports:
clock    in   1        rising-edge clock
reset_n  in   1        asynchronous active-low reset
address  in   ADDR_W   word address for read and write
data     in   DATA_W   write data
wren     in   1        write enable
ben      in   LANES    per-lane write enable; lane i covers data[i*LANE_W +: LANE_W]
rden     in   1        read enable
clear    in   1        single-cycle request to zero the whole array
q        out  DATA_W   registered read data
q_valid  out  1        high for one cycle when q was updated by a read
busy     out  1        high while clearing; accesses are ignored

Behaviour:
- Reset (reset_n=0, asynchronous): q=0, q_valid=0, busy=1, state=CLEAR, clear counter cnt=0. The array is not reset directly; the FSM zeroes it.
- FSM states: CLEAR and IDLE.
- CLEAR: on each rising edge, mem[cnt]<=0 and cnt<=cnt+1. On the edge that writes cnt=DEPTH-1: state<=IDLE, busy<=0, cnt<=0. Busy stays high for exactly DEPTH edges after reset release.
- In CLEAR, wren, rden and clear are ignored. q holds its value and q_valid=0.
- IDLE: clear=1 sampled on an edge sets state<=CLEAR and busy<=1. No write or read is performed on that edge (clear has priority over wren/rden).
- Write (IDLE, wren=1): for each lane i with ben[i]=1, mem[address] lane i <= data lane i. Lanes with ben[i]=0 are unchanged. wren=1 with ben=0 is a no-op.
- Read (IDLE, rden=1): q<=mem[address] on the same edge, so latency is 1 cycle; q_valid<=1 for that cycle only. When rden=0, q holds its last value and q_valid<=0.
- Same-edge read and write to the same address:
  - RDW_NEW=0: q gets the pre-write word.
  - RDW_NEW=1: q gets the merged word (written lanes take new data, other lanes keep old data).
- Reads and writes to different addresses on the same edge are independent.
- Address wrap-around: none; every address value is legal because DEPTH=2**ADDR_W.
- Reset asserted mid-CLEAR or mid-access restarts CLEAR from cnt=0. Any in-flight write on that edge is lost.
- No X may propagate to q after reset. The first read after busy falls returns 0 for every address.

Test Plan:
1. Release reset with defaults -> busy=1 for exactly 32 edges, then 0. Reads of addresses 0x00, 0x1F and 0x0A return q=0x0 with q_valid=1 one cycle after rden.
2. Write 0xA@0x01, 0xB@0x02, 0xC@0x03 (ben=1), then rden at 0x01/0x02/0x03 -> q=0xA, 0xB, 0xC, each one cycle after its address. Holding rden=0 keeps q at 0xC with q_valid=0.
3. DATA_W=8, LANE_W=4: write 0x5A@0x04, then write 0xF3 with ben=2'b10 -> readback 0xFA. Write with ben=0 leaves 0xFA.
4. Same-edge write 0x7@0x05 (old value 0x2) with rden@0x05 -> q=0x2 when RDW_NEW=0; q=0x7 when RDW_NEW=1. A following read returns 0x7 in both modes.
5. Fill 0x10 with 0x9, pulse clear with wren=1 to 0x11 -> busy=1 for 32 edges; 0x11 not written; afterwards 0x10 reads 0x0. rden during busy gives q_valid=0 and q unchanged.
6. Assert reset_n=0 at cnt=12 of a clear, release -> busy high for a full 32 edges again. All locations read 0 afterwards.
